// File: rtl/led_ctrl.sv
// Multi-channel LED driver: per-channel off/on/blink/PWM modes configured via a
// single-cycle write port, with a shared ms-tick prescaler and 8-bit PWM counter.
module led_ctrl #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned PERIOD_W   = 16,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [PERIOD_W-1:0] wr_arg,
    output logic                tick,
    output logic [NUM_CH-1:0]   led
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned PWM_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [NUM_CH-1:0]   led_q, led_d;
    logic [NUM_CH-1:0]   level_c;
    logic                wr_ok_c;

    mode_e               mode_q  [NUM_CH];
    mode_e               mode_d  [NUM_CH];
    logic [PERIOD_W-1:0] arg_q   [NUM_CH];
    logic [PERIOD_W-1:0] arg_d   [NUM_CH];
    logic [PERIOD_W-1:0] cnt_q   [NUM_CH];
    logic [PERIOD_W-1:0] cnt_d   [NUM_CH];
    logic                phase_q [NUM_CH];
    logic                phase_d [NUM_CH];

    assign tick = tick_q;
    assign led  = led_q;

    // Shared timebase: prescaler wrap produces a one-cycle registered tick.
    always_comb begin
        presc_d   = presc_q + PRE_W'(1);
        tick_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        if (presc_q == PRE_W'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
    end

    assign wr_ok_c = wr_en && (32'(wr_ch) < NUM_CH);

    // Per-channel next state; a write on the same edge as a tick overrides it.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mode_d[i]  = mode_q[i];
            arg_d[i]   = arg_q[i];
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
            if (mode_q[i] == MODE_BLINK) begin
                cnt_d[i]   = cnt_q[i];
                phase_d[i] = phase_q[i];
                if (tick_q) begin
                    // arg of 0 behaves as a half-period of 1, so the wrap value is 0
                    if (cnt_q[i] == ((arg_q[i] == '0) ? '0 : arg_q[i] - PERIOD_W'(1))) begin
                        cnt_d[i]   = '0;
                        phase_d[i] = ~phase_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                    end
                end
            end
            if (wr_ok_c && (wr_ch == CH_W'(i))) begin
                mode_d[i]  = mode_e'(wr_mode);
                arg_d[i]   = wr_arg;
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
            end
        end
    end

    // Channel level from current state; the pin register adds one edge of latency.
    always_comb begin
        level_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            case (mode_q[i])
                MODE_OFF:   level_c[i] = 1'b0;
                MODE_ON:    level_c[i] = 1'b1;
                MODE_BLINK: level_c[i] = phase_q[i];
                MODE_PWM:   level_c[i] = (pwm_cnt_q < arg_q[i][PWM_W-1:0]);
                default:    level_c[i] = 1'b0;
            endcase
        end
        led_d = level_c ^ {NUM_CH{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= {NUM_CH{ACTIVE_LOW}};
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i]  <= MODE_OFF;
                arg_q[i]   <= '0;
                cnt_q[i]   <= '0;
                phase_q[i] <= 1'b0;
            end
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i]  <= mode_d[i];
                arg_q[i]   <= arg_d[i];
                cnt_q[i]   <= cnt_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: stimulus queues expected observations, a negedge
// monitor pops and compares them against a 4-channel and an inverted 3-channel DUT.
module tb_led_ctrl;

    localparam int K_LED  = 0;
    localparam int K_TICK = 1;
    localparam int K_CNT  = 2;
    localparam int K_LED2 = 3;

    typedef struct {
        string name;
        int    kind;
        int    exp;
        int    mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [1:0]  wr_mode = '0;
    logic [15:0] wr_arg = '0;
    logic        tick, tick2;
    logic [3:0]  led;
    logic [2:0]  led2;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   c = 0;
    bit   cnt_en = 1'b0;
    bit   done = 1'b0;
    int   hi_cnt = 0;

    led_ctrl #(.NUM_CH(4), .TICK_DIV(4), .PERIOD_W(16), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_arg(wr_arg), .tick(tick), .led(led)
    );

    led_ctrl #(.NUM_CH(3), .TICK_DIV(4), .PERIOD_W(16), .ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_arg(wr_arg), .tick(tick2), .led(led2)
    );

    always #5 clk = ~clk;

    // Monitor: drain queued expectations, then accumulate the PWM high-cycle window.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            int   act;
            e = q.pop_front();
            case (e.kind)
                K_LED:   act = int'(led) & e.mask;
                K_TICK:  act = int'(tick);
                K_CNT:   act = hi_cnt;
                default: act = int'(led2) & e.mask;
            endcase
            n_vec++;
            if (act != e.exp) begin
                n_err++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.exp, c);
            end
        end
        if (cnt_en) hi_cnt += int'(led[3]);
        else        hi_cnt = 0;
    end

    // Watchdog: the stimulus must complete within a bounded time.
    initial begin
        #100000;
        if (!done) begin
            n_err++;
            $display("FAIL timeout: stimulus did not complete (cycle %0d)", c);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic check_now(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, c);
        end
    endtask

    task automatic push(input string name, input int kind, input int exp, input int mask);
        exp_t e;
        e.name = name; e.kind = kind; e.exp = exp; e.mask = mask;
        q.push_back(e);
    endtask

    task automatic check_at(input int cyc, input string name, input int kind,
                            input int exp, input int mask);
        while (c < cyc) step();
        push(name, kind, exp, mask);
    endtask

    task automatic write_at(input int cyc, input logic [1:0] ch, input logic [1:0] mode,
                            input logic [15:0] arg);
        while (c < cyc) step();
        wr_en = 1'b1; wr_ch = ch; wr_mode = mode; wr_arg = arg;
        step();
        wr_en = 1'b0;
    endtask

    // ch3 pwm written so its level reaches led from cycle 'start'; count 512 cycles.
    task automatic pwm_window(input int start, input logic [15:0] duty, input string name,
                              input int exp);
        write_at(start - 2, 2'd3, 2'b11, duty);
        while (c < start) step();
        cnt_en = 1'b1;
        while (c < start + 512) step();
        cnt_en = 1'b0;
        push(name, K_CNT, exp, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_led", int'(led), 0);
        check_now("reset_tick", int'(tick), 0);
        check_now("reset_led_al", int'(led2), 7);
        rst_n = 1'b1;
        c = 0;

        for (int k = 1; k <= 20; k++) check_at(k, "tick_timing", K_TICK, (k % 4 == 0) ? 1 : 0, 0);

        // Blink half-period 3 on ch1
        write_at(21, 2'd1, 2'b10, 16'd3);
        check_at(23, "blink3_start", K_LED, 0, 2);
        check_at(33, "blink3_dark_end", K_LED, 0, 2);
        check_at(34, "blink3_rise", K_LED, 2, 2);
        check_at(45, "blink3_high_end", K_LED, 2, 2);
        check_at(46, "blink3_fall", K_LED, 0, 2);
        check_at(57, "blink3_low_end", K_LED, 0, 2);
        check_at(58, "blink3_rise2", K_LED, 2, 2);

        // arg=0 acts as half-period 1
        write_at(61, 2'd1, 2'b10, 16'd0);
        check_at(65, "blink0_dark", K_LED, 0, 2);
        check_at(66, "blink0_rise", K_LED, 2, 2);
        check_at(69, "blink0_high", K_LED, 2, 2);
        check_at(70, "blink0_fall", K_LED, 0, 2);
        check_at(74, "blink0_rise2", K_LED, 2, 2);

        // ch0 blink, then ch2 written in a tick cycle
        write_at(75, 2'd0, 2'b10, 16'd2);
        check_at(81, "coll_ch0_dark", K_LED, 0, 5);
        check_at(82, "coll_ch0_rise", K_LED, 1, 5);
        write_at(84, 2'd2, 2'b10, 16'd2);
        check_at(89, "coll_pre", K_LED, 1, 5);
        check_at(90, "coll_ch2_held", K_LED, 0, 5);
        check_at(93, "coll_ch2_dark", K_LED, 0, 5);
        check_at(94, "coll_ch2_rise", K_LED, 4, 5);
        check_at(98, "coll_both_high", K_LED, 5, 5);

        // Write latency: visible one edge after the state changes
        write_at(100, 2'd3, 2'b01, 16'd0);
        check_at(101, "on_latency", K_LED, 0, 8);
        check_at(102, "on_visible", K_LED, 8, 8);

        pwm_window(112, 16'd64, "pwm_duty64", 128);
        pwm_window(632, 16'd0, "pwm_duty0", 0);
        pwm_window(1152, 16'd255, "pwm_duty255", 510);

        // Clear ch0..2 back-to-back, then write ch3 (illegal for the 3-channel DUT)
        write_at(1670, 2'd0, 2'b00, 16'd0);
        write_at(1671, 2'd1, 2'b00, 16'd0);
        write_at(1672, 2'd2, 2'b00, 16'd0);
        check_at(1675, "clear_all", K_LED, 0, 7);
        check_at(1675, "clear_all_al", K_LED2, 7, 7);
        write_at(1676, 2'd3, 2'b01, 16'd0);
        check_at(1680, "illegal_ch_al", K_LED2, 7, 7);
        check_at(1680, "ch3_on", K_LED, 8, 15);

        // Back-to-back writes to ch0: last one wins
        write_at(1680, 2'd0, 2'b01, 16'd0);
        write_at(1681, 2'd0, 2'b00, 16'd0);
        check_at(1682, "b2b_first", K_LED, 1, 1);
        check_at(1683, "b2b_last_wins", K_LED, 0, 1);

        // Mid-operation reset
        write_at(1690, 2'd0, 2'b01, 16'd0);
        write_at(1691, 2'd1, 2'b11, 16'd128);
        check_at(1700, "pre_reset", K_LED, 9, 9);
        check_at(1700, "pre_reset_al", K_LED2, 0, 1);
        rst_n = 1'b0;
        check_at(1701, "midreset_led", K_LED, 0, 15);
        check_at(1701, "midreset_tick", K_TICK, 0, 0);
        check_at(1701, "midreset_al", K_LED2, 7, 7);
        while (c < 1702) step();
        rst_n = 1'b1;
        check_at(1703, "post_reset_led", K_LED, 0, 15);
        check_at(1705, "post_reset_tick0", K_TICK, 0, 0);
        check_at(1706, "post_reset_tick1", K_TICK, 1, 0);
        check_at(1720, "post_reset_off", K_LED, 0, 15);
        check_at(1720, "post_reset_off_al", K_LED2, 7, 7);

        repeat (3) step();
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Parametrised multi-channel LED driver; next generation of the board-level heartbeat blinker.
- Each channel is independently configured through a single-cycle register write port. Modes: off, on, blink with programmable half-period in ms ticks, or 8-bit PWM dimming.
- Sits at top level between the core's debug/status logic and the board LED pins.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- TICK_DIV, 50000, clk cycles per blink tick (1 ms at 50 MHz); must be >= 2.
- PERIOD_W, 16, width of the per-channel half-period / duty field.
- ACTIVE_LOW, 0, when 1 the led outputs are inverted at the pin register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  config write strobe, one cycle per write.
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- wr_mode  in  2  00 off, 01 on, 10 blink, 11 pwm.
- wr_arg  in  PERIOD_W  blink half-period in ticks; pwm duty in low 8 bits.
- tick  out  1  one-cycle pulse every TICK_DIV clocks (debug/shared timebase).
- led  out  NUM_CH  registered LED drive, bit i = channel i.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, tick=0, pwm_cnt=0.
  - All channel modes=off, args=0, tick counters=0, blink phases=0.
  - led = all 1s if ACTIVE_LOW else all 0s.
  - Reset has priority over wr_en and over tick. Reset asserted mid-blink or mid-PWM returns every channel to off immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered and is 1 for exactly the cycle after the prescaler's wrap edge. First tick after reset is high in cycle TICK_DIV (reset-release edge counts as cycle 0).
- PWM counter: 8-bit free-running, increments every clk, wraps 255->0. Shared by all channels.
- Config write:
  - On a clk edge with wr_en=1 and wr_ch<NUM_CH, the channel's mode and arg load.
  - The same edge clears that channel's tick counter and sets its blink phase to 0.
  - wr_ch>=NUM_CH is ignored with no side effects.
  - A write to a channel coinciding with tick: the write wins and the tick is not counted for that channel. Other channels count normally.
  - Back-to-back writes are allowed each cycle; the last write to a channel wins.
- Blink (mode 10):
  - Effective half-period P = arg, with arg=0 treated as 1.
  - On each tick: if cnt==P-1, set cnt=0 and toggle phase; else cnt=cnt+1.
  - Channel level = phase, so the channel is dark for the first P ticks after a write, then toggles every P ticks.
- Modes off / on / pwm:
  - Off (00): level 0. On (01): level 1.
  - PWM (11): level = (pwm_cnt < arg[7:0]). duty 0 -> always 0; duty 255 -> high 255 of every 256 cycles. Tick counter and phase are held at 0.
- Output:
  - led[i] <= level_i XOR ACTIVE_LOW, registered one edge after the state it reflects.
  - A write at edge N is therefore visible on led after edge N+1.
  - Arithmetic is unsigned. Counters are PERIOD_W bits and never exceed P-1.

Test Plan:
- Reset: TICK_DIV=4, NUM_CH=4, hold rst_n=0 for 3 cycles -> led=4'b0000, tick=0. With ACTIVE_LOW=1 -> led=4'b1111.
- Tick timing: TICK_DIV=4, run 20 cycles after reset -> tick high in cycles 4, 8, 12, 16, 20 only, each exactly one cycle wide.
- Blink: write ch1 mode=10 arg=3 -> led[1] low for 3 ticks (12 clk), high for 3 ticks, low again. Repeat with arg=0 -> led[1] toggles every tick.
- Write collision: write ch2 blink arg=2 in the same cycle tick pulses -> ch2 counter stays 0 and its first toggle lands 2 ticks later. ch0 already in blink continues on schedule.
- PWM: write ch3 mode=11 arg=64, observe 512 cycles -> led[3] high exactly 128 cycles. duty=0 -> 0 high cycles; duty=255 -> 510 high cycles.
- Illegal channel and mid-op reset: NUM_CH=3 with wr_ch=3 -> no led change. Assert rst_n=0 while ch0 is on and ch1 is in pwm -> led=0 on the edge after reset, and all modes read back as off once reset is released.
